// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and helpers for the iterative shift-add multiplier.
//   mode_e  : per-operation product flavour selected on in_mode
//   state_e : control FSM states
//   mode_a_signed / mode_b_signed : which operands are read as two's complement
package mul_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UNS   = 2'b00,   // full unsigned product
        MODE_SGN   = 2'b01,   // full signed product
        MODE_MIX   = 2'b10,   // A signed, B unsigned
        MODE_TRUNC = 2'b11    // unsigned, low half only
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic mode_a_signed(input mode_e mode);
        return (mode == MODE_SGN) || (mode == MODE_MIX);
    endfunction

    function automatic logic mode_b_signed(input mode_e mode);
        return (mode == MODE_SGN);
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: valid/ready operand and result channels of mul_seq.
//   in_valid/in_ready/in_mode/in_a/in_b : operation request (producer -> block)
//   out_valid/out_ready/out_y           : product (block -> consumer)
//   busy                                : block is running or holding a result
// master: producer/consumer side; slave: the multiplier.
interface mul_seq_if #(
    parameter int LEN = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_mode;
    logic [LEN-1:0]     in_a;
    logic [LEN-1:0]     in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*LEN-1:0]   out_y;
    logic               busy;

    modport master (
        output in_valid, in_mode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, busy
    );
endinterface

// File: rtl/mul_seq_signfix.sv
// mul_seq_signfix: combinational conditional two's-complement negate.
//   neg : 1 -> y = -x, 0 -> y = x
//   x   : W-bit input
//   y   : W-bit output
// Used both to take operand magnitudes and to re-apply the product sign.
// Negating 0 yields 0, so a zero product never picks up a sign artefact.
module mul_seq_signfix #(
    parameter int W = 16
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier with run-time signedness mode.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : mul_seq_if slave (operand channel, result channel, busy)
// One product bit per cycle over LEN cycles on operand magnitudes; the sign
// is re-applied on the final edge. A new operation may be accepted on the
// same edge a result is handed off, bypassing IDLE.
// Optional feature macro MUL_SEQ_EARLY_EXIT_EN: finish as soon as the
// remaining multiplier bits are all zero, aligning the accumulator with a
// single variable right shift.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int LEN = 16
) (
    input  logic      clk,
    input  logic      rst,
    mul_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(LEN + 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic               neg_q, neg_d;
    logic [LEN-1:0]     mag_a_q, mag_a_d;
    logic [LEN-1:0]     mag_b_q, mag_b_d;
    logic [2*LEN:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*LEN-1:0]   y_q, y_d;

    // Operand magnitudes, taken only where the mode reads the operand as signed.
    logic               a_neg, b_neg;
    logic [LEN-1:0]     in_mag_a, in_mag_b;

    assign a_neg = mode_a_signed(mode_e'(bus.in_mode)) & bus.in_a[LEN-1];
    assign b_neg = mode_b_signed(mode_e'(bus.in_mode)) & bus.in_b[LEN-1];

    mul_seq_signfix #(.W(LEN)) u_fix_a (.neg(a_neg), .x(bus.in_a), .y(in_mag_a));
    mul_seq_signfix #(.W(LEN)) u_fix_b (.neg(b_neg), .x(bus.in_b), .y(in_mag_b));

    // One iteration: add into the upper half, then shift the whole
    // accumulator right. The add needs LEN+1 bits; the bit it carries into
    // is always zero beforehand because the previous shift cleared it.
    logic [LEN:0]       sum_hi;
    logic [2*LEN:0]     acc_it;
    logic [LEN-1:0]     mag_b_it;
    logic [CNT_W-1:0]   cnt_it;
    logic               run_last;
    logic [2*LEN-1:0]   prod_raw, prod_signed, y_final;

    assign sum_hi   = acc_q[2*LEN:LEN] + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
    assign acc_it   = {sum_hi, acc_q[LEN-1:0]} >> 1;
    assign mag_b_it = mag_b_q >> 1;
    assign cnt_it   = cnt_q - CNT_W'(1);

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // Remaining iterations would only shift; do all of them at once.
    assign run_last = (cnt_it == '0) || (mag_b_it == '0);
    assign prod_raw = acc_it[2*LEN-1:0] >> cnt_it;
`else
    assign run_last = (cnt_it == '0);
    assign prod_raw = acc_it[2*LEN-1:0];
`endif

    mul_seq_signfix #(.W(2*LEN)) u_fix_y (.neg(neg_q), .x(prod_raw), .y(prod_signed));

    assign y_final = (mode_q == MODE_TRUNC) ? {{LEN{1'b0}}, prod_raw[LEN-1:0]} : prod_signed;

    always_comb begin
        logic accept;
        state_d       = state_q;
        mode_d        = mode_q;
        neg_d         = neg_q;
        mag_a_d       = mag_a_q;
        mag_b_d       = mag_b_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        y_d           = y_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                acc_d    = acc_it;
                mag_b_d  = mag_b_it;
                cnt_d    = cnt_it;
                if (run_last) begin
                    y_d     = y_final;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    accept  = bus.in_valid;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            mode_d  = mode_e'(bus.in_mode);
            neg_d   = a_neg ^ b_neg;
            mag_a_d = in_mag_a;
            mag_b_d = in_mag_b;
            acc_d   = '0;
            cnt_d   = CNT_W'(LEN);
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_UNS;
            neg_q   <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign bus.out_y = y_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq. The driver pushes the expected
// product and latency when an operation is accepted; a negedge monitor pops
// and compares whenever a result is handed off, and also checks latency,
// output stability under backpressure and in_ready during stalls.
module tb_mul_seq;
    localparam int LEN = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_seq_if #(.LEN(LEN)) bus ();

    mul_seq #(.LEN(LEN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2*LEN-1:0] y;
        int               lat;
        int               acc_cyc;
        logic [1:0]       mode;
        logic [LEN-1:0]   a;
        logic [LEN-1:0]   b;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   rand_stall  = 1'b0;
    bit   ready_force = 1'b1;
    bit   seen = 1'b0;
    logic [2*LEN-1:0] held;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: product of the operands as integers under the mode's reading.
    function automatic logic [2*LEN-1:0] ref_y(input logic [1:0] m, input logic [LEN-1:0] a,
                                               input logic [LEN-1:0] b);
        logic signed [2*LEN+1:0] ea, eb, p;
        logic [LEN-1:0] lo;
        if (m == 2'b11) begin
            lo = a * b;
            return {{LEN{1'b0}}, lo};
        end
        if (m == 2'b01 || m == 2'b10) ea = $signed(a);
        else                          ea = $signed({1'b0, a});
        if (m == 2'b01)               eb = $signed(b);
        else                          eb = $signed({1'b0, b});
        p = ea * eb;
        return p[2*LEN-1:0];
    endfunction

    function automatic int exp_lat(input logic [1:0] m, input logic [LEN-1:0] b);
        logic [LEN-1:0] mb;
        int hb = -1;
        mb = (m == 2'b01 && b[LEN-1]) ? -b : b;
        for (int i = 0; i < LEN; i++) if (mb[i]) hb = i;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        return (hb + 1 < 1) ? 1 : hb + 1;
`else
        return LEN;
`endif
    endfunction

    function automatic logic [LEN-1:0] rnd_op();
        logic [LEN-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = LEN'(1);
            2: v = {LEN{1'b1}};
            3: v = {1'b1, {(LEN-1){1'b0}}};
            4: v = LEN'($urandom_range(0, 15));
            default: v = LEN'($urandom);
        endcase
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic drive_exp(input logic [1:0] m, input logic [LEN-1:0] a,
                             input logic [LEN-1:0] b, input logic [2*LEN-1:0] y);
        exp_t e;
        bit ok = 1'b0;
        bus.in_mode  = m;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", bus.in_ready);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
        end
        e.y = y; e.lat = exp_lat(m, b); e.acc_cyc = cyc + 1;
        e.mode = m; e.a = a; e.b = b;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Operands must be ignored after the accept edge.
        bus.in_a     = LEN'($urandom);
        bus.in_b     = LEN'($urandom);
        bus.in_mode  = 2'($urandom);
    endtask

    task automatic drive(input logic [1:0] m, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        drive_exp(m, a, b, ref_y(m, a, b));
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_stall) bus.out_ready = ($urandom_range(0, 3) != 0);
        else            bus.out_ready = ready_force;
    end

    // Monitor: one negedge per cycle, so each handshake is seen exactly once.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            check("busy_in_done", 64'(bus.busy), 64'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: out_valid=1 with y=%h, required no result", bus.out_y);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    held = bus.out_y;
                    check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
                end else begin
                    check("hold_stable", 64'(bus.out_y), 64'(held));
                end
                if (!bus.out_ready) begin
                    check("in_ready_stall", 64'(bus.in_ready), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(bus.out_y), 64'(e.y));
                    $display("txn mode=%0d a=%h b=%h y=%h req=%h", e.mode, e.a, e.b, bus.out_y, e.y);
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'b00;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_out_y",     64'(bus.out_y),     64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed products, back to back through the DONE bypass.
        drive_exp(2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        drive_exp(2'b01, 16'h8000, 16'h8000, 32'h40000000);
        drive_exp(2'b01, 16'hFFFF, 16'h0003, 32'hFFFFFFFD);
        drive_exp(2'b10, 16'hFFFF, 16'hFFFF, 32'hFFFF0001);
        drive_exp(2'b11, 16'hFFFF, 16'hFFFF, 32'h00000001);
        drive_exp(2'b01, 16'h0000, 16'h8000, 32'h00000000);
        drive_exp(2'b01, 16'h8000, 16'hFFFF, 32'h00008000);
        drive_exp(2'b10, 16'h8000, 16'hFFFF, 32'h80008000);
        drive_exp(2'b00, 16'h1234, 16'h0000, 32'h00000000);
        drive_exp(2'b00, 16'h1234, 16'h0001, 32'h00001234);
        drain();

        // Backpressure: hold the result for 20 cycles, then hand off and accept together.
        ready_force = 1'b0;
        @(posedge clk); #1;
        drive_exp(2'b00, 16'h1234, 16'h5678, 32'h06260060);
        for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        repeat (20) @(negedge clk);
        ready_force = 1'b1;
        @(posedge clk); #1;
        drive_exp(2'b01, 16'hFFFE, 16'h0005, 32'hFFFFFFF6);
        drain();

        // Asynchronous reset mid-run with counter at 7.
        drive(2'b00, 16'hABCD, 16'hFFFF);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_in_ready",  64'(bus.in_ready),  64'd1);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy",      64'(bus.busy),      64'd0);
        check("arst_out_y",     64'(bus.out_y),     64'd0);
        rst = 1'b0;
        repeat (LEN + 5) @(posedge clk);
        #1;
        check("arst_no_valid", 64'(bus.out_valid), 64'd0);

        // Randomised soak with consumer stalls and idle gaps.
        rand_stall = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            drive(2'($urandom), rnd_op(), rnd_op());
        end
        drain();
        rand_stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Iterative shift-add multiplier, parametrised in operand width, with run-time selectable signedness mode and valid/ready handshakes on both sides. It is the sequential successor of the combinational multiplier tops: the same four product flavours (truncated, full unsigned, full signed, full mixed) are chosen per operation instead of at generation time. It trades latency for area and sits between a producer and a consumer that both obey valid/ready.

Parameters:
LEN, 16, operand width in bits; legal range 2..64.
CNT_W, $clog2(LEN+1), width of the iteration counter; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operands and mode present.
in_ready  output  1  block can accept an operation.
in_mode  input  2  00 full unsigned, 01 full signed, 10 full mixed (A signed, B unsigned), 11 truncated.
in_a  input  LEN  multiplicand A.
in_b  input  LEN  multiplier B.
out_valid  output  1  result held on out_y.
out_ready  input  1  consumer takes the result.
out_y  output  2*LEN  product.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high: assertion forces the state to IDLE immediately, without waiting for a clock edge.
- Reset values: in_ready=1, out_valid=0, busy=0, out_y=0, counter=0.
- FSM states are IDLE, RUN and DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - latch the mode;
  - latch magA=|A| and magB=|B|, taking the absolute value only where that operand is signed under the mode;
  - latch neg = signA XOR signB, counting only the signed operands;
  - clear the accumulator, load counter=LEN, go to RUN.
- Magnitude of -2^(LEN-1) is 2^(LEN-1). It fits in LEN unsigned bits, so no overflow case exists.
- RUN: in_ready=0. Each cycle:
  - if magB[0]=1, add magA into the upper half of the 2*LEN+1-bit accumulator;
  - shift the accumulator right by 1 and shift magB right by 1;
  - decrement the counter.
- RUN ends when counter reaches 0. The last iteration's edge writes out_y, applying two's-complement negation when neg=1, and the FSM enters DONE.
- Truncated mode (11): unsigned arithmetic. out_y[2*LEN-1:LEN] is forced to 0 and out_y[LEN-1:0] is the low product half.
- Latency: accept edge at cycle k gives out_valid=1 after edge k+LEN (fixed; see Optional Feature).
- DONE: out_valid=1; out_y and out_valid are held stable until out_ready=1.
  - On the handshake edge, out_valid drops to 0.
  - If in_valid=1 on that same edge, the new operation is accepted directly, bypassing IDLE (in_ready=out_ready in DONE). This gives a back-to-back throughput of one result per LEN+1 cycles.
- Backpressure: out_ready=0 stalls indefinitely in DONE, with no loss and no corruption.
- in_a, in_b and in_mode are sampled only on the accept edge. Changes while in RUN or DONE are ignored.
- Reset asserted mid-RUN or in DONE: the operation is discarded, no out_valid is emitted, and the block returns to the reset values.
- Zero operand: the result is 0, never -0 artefacts, because negation of 0 yields 0.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- Defined: in RUN, when the remaining magB is 0, the block skips the remaining iterations. The accumulator is aligned by shifting right by counter in a single cycle, and the FSM finishes that cycle. Latency becomes max(1, index of highest set bit of magB + 1) cycles; B=0 finishes 1 cycle after accept.
- Undefined: fixed LEN-cycle latency, no barrel shifter.
- Results are bit-identical either way.

Decomposition:
- Package mul_seq_pkg holds:
  - the mode enum (MODE_UNS=2'b00, MODE_SGN=2'b01, MODE_MIX=2'b10, MODE_TRUNC=2'b11);
  - the state enum (ST_IDLE, ST_RUN, ST_DONE);
  - the function mode_a_signed(mode) and the function mode_b_signed(mode).
- One sub-module, mul_seq_signfix: a combinational conditional negate (magnitude on input and re-sign on output), instantiated twice for the input operands and once for the result.

Test Plan:
- LEN=16, mode 00, A=16'hFFFF, B=16'hFFFF -> out_y=32'hFFFE0001 after exactly 16 cycles (feature off).
- Mode 01, A=16'h8000, B=16'h8000 -> out_y=32'h40000000; A=16'hFFFF (-1), B=16'h0003 -> 32'hFFFFFFFD.
- Mode 10, A=16'hFFFF, B=16'hFFFF -> out_y=32'hFFFF0001 (-1 × 65535); mode 11 with the same operands -> 32'h00000001.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_y stays stable and in_ready=0. Then out_ready=1 with in_valid=1 and a new pair on the same edge -> the new operation is accepted and the next result arrives LEN cycles later.
- Reset pulse of 1 ns mid-RUN (counter=7), asynchronous to clk -> outputs go to reset values immediately and no spurious out_valid follows.
- Randomised soak, 10k operations, all modes and random ready stalls, LEN in {4,16,33}: every result matches the reference A*B for the selected mode. With MUL_SEQ_EARLY_EXIT_EN, B=0 gives a latency of 1 and B=1 gives a latency of 1.
